// File: rtl/tpu_pkg.sv
// Shared types for the convolution result sink.
//   state_t      : sink FSM states
//   fifo_entry_t : one buffered result {last, data}
//   n_out()      : number of outputs per frame for an MxM input and CxC kernel
package tpu_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

  function automatic int unsigned n_out(input int unsigned m, input int unsigned c);
    return (m - c + 1) * (m - c + 1);
  endfunction

endpackage

// File: rtl/conv_result_sink_fifo.sv
// Synchronous FIFO with extra-bit pointers.
//   clk, rst      : clock, async active-low reset (clears pointers only)
//   push/push_data: write request; accepted when not full or when popping
//   pop           : read request; ignored when empty
//   head          : data at the read pointer
//   full, empty   : occupancy flags
module sync_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/conv_result_sink.sv
// Captures convolution sums on conv_done, applies ReLU and arithmetic shift,
// buffers them in a FIFO and streams them out with valid/ready.
//   clk, rst        : clock, async active-low reset
//   start           : arms one frame (IDLE only)
//   conv_done/data  : engine result pulse and signed sum
//   out_valid/ready : output handshake; out_data/out_last from FIFO head
//   frame_done      : one-cycle pulse once the frame has fully drained
//   overflow        : sticky, a result was dropped on a full FIFO
//   busy            : FSM not in IDLE
module conv_result_sink
  import tpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_W,
  parameter int unsigned MATRIX_DIM = 16,
  parameter int unsigned CONV_DIM   = 3,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned SHIFT      = 0,
  parameter int unsigned RELU       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  conv_done,
  input  logic [DATA_WIDTH-1:0] conv_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  frame_done,
  output logic                  overflow,
  output logic                  busy
);

  localparam int unsigned N_OUT   = n_out(MATRIX_DIM, CONV_DIM);
  localparam int unsigned CNT_W   = $clog2(N_OUT + 1);
  localparam int unsigned ENTRY_W = $bits(fifo_entry_t);

  state_t                  state;
  state_t                  state_next;
  logic [CNT_W-1:0]        cnt;
  logic                    stage_valid;
  fifo_entry_t             stage_entry;
  fifo_entry_t             head_entry;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_pop;
  logic                    arm;
  logic                    capture;
  logic                    last_sample;
  logic                    drained;
  logic signed [DATA_WIDTH-1:0] relu_v;
  logic signed [DATA_WIDTH-1:0] proc_v;

  assign arm         = (state == IDLE) && start;
  assign capture     = (state == COLLECT) && conv_done;
  assign last_sample = (cnt == CNT_W'(N_OUT - 1));
  assign drained     = (state == DRAIN) && !stage_valid && fifo_empty;
  assign fifo_pop    = out_ready && !fifo_empty;

  // ReLU then arithmetic right shift
  always_comb begin
    relu_v = $signed(conv_data);
    if ((RELU != 0) && conv_data[DATA_WIDTH-1]) relu_v = '0;
    proc_v = relu_v >>> SHIFT;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = COLLECT;
      COLLECT: if (conv_done && last_sample) state_next = DRAIN;
      DRAIN:   if (drained) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sample counter, stage register and sticky overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      stage_valid <= 1'b0;
      stage_entry <= '0;
      overflow    <= 1'b0;
    end else begin
      stage_valid <= capture;
      if (capture) begin
        stage_entry.data <= DATA_W'(proc_v);
        stage_entry.last <= last_sample;
      end
      if (arm)          cnt <= '0;
      else if (capture) cnt <= cnt + CNT_W'(1);
      if (arm) overflow <= 1'b0;
      else if (stage_valid && fifo_full && !fifo_pop) overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (stage_valid),
    .push_data (stage_entry),
    .pop       (fifo_pop),
    .head      (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Head is gated so idle outputs read as zero rather than stale storage.
  assign out_valid  = !fifo_empty;
  assign out_data   = out_valid ? DATA_WIDTH'(head_entry.data) : '0;
  assign out_last   = out_valid && head_entry.last;
  // Decoded from registered state so a coincident start sees DRAIN and is ignored.
  assign frame_done = drained;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_conv_result_sink.sv
// Bench for conv_result_sink: three instances (defaults, SHIFT=2/RELU=1,
// SHIFT=2/RELU=0) sharing stimulus; table vectors plus stream scoreboard.
module tb_conv_result_sink;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       conv_done;
  logic [7:0] conv_data;
  logic       out_ready;

  logic       ov_a, ol_a, fd_a, of_a, bz_a;
  logic [7:0] od_a;
  logic       ov_b, ol_b, fd_b, of_b, bz_b;
  logic [7:0] od_b;
  logic       ov_c, ol_c, fd_c, of_c, bz_c;
  logic [7:0] od_c;

  conv_result_sink dut_a (
    .clk(clk), .rst(rst_n), .start(start), .conv_done(conv_done), .conv_data(conv_data),
    .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a), .out_last(ol_a),
    .frame_done(fd_a), .overflow(of_a), .busy(bz_a)
  );

  conv_result_sink #(.SHIFT(2), .RELU(1)) dut_b (
    .clk(clk), .rst(rst_n), .start(start), .conv_done(conv_done), .conv_data(conv_data),
    .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b), .out_last(ol_b),
    .frame_done(fd_b), .overflow(of_b), .busy(bz_b)
  );

  conv_result_sink #(.SHIFT(2), .RELU(0)) dut_c (
    .clk(clk), .rst(rst_n), .start(start), .conv_done(conv_done), .conv_data(conv_data),
    .out_valid(ov_c), .out_ready(out_ready), .out_data(od_c), .out_last(ol_c),
    .frame_done(fd_c), .overflow(of_c), .busy(bz_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] din;
    logic [7:0] ea;
    logic [7:0] eb;
    logic [7:0] ec;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } exp_t;

  vec_t vecs [7];
  exp_t exp_q [$];
  exp_t mon_e;
  bit   mon_en = 0;
  int   pop_cnt = 0;
  int   fd_cnt = 0;
  int   fd_pop_at = -1;

  // Stream scoreboard on instance A, sampled mid-cycle
  always @(negedge clk) begin
    if (mon_en) begin
      if (ov_a && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop actual_data=0x%0h required=no_pop", od_a);
        end else begin
          mon_e = exp_q.pop_front();
          check("stream_data", 32'(od_a), 32'(mon_e.d));
          check("stream_last", 32'(ol_a), 32'(mon_e.l));
          pop_cnt++;
        end
      end
      if (fd_a) begin
        fd_cnt++;
        fd_pop_at = pop_cnt;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //               din     A      B(>>2) C(no relu,>>2)
    vecs[0] = '{8'h25, 8'h25, 8'h09, 8'h09};
    vecs[1] = '{8'h7F, 8'h7F, 8'h1F, 8'h1F};
    vecs[2] = '{8'hFD, 8'h00, 8'h00, 8'hFF};
    vecs[3] = '{8'hF8, 8'h00, 8'h00, 8'hFE};
    vecs[4] = '{8'h80, 8'h00, 8'h00, 8'hE0};
    vecs[5] = '{8'h01, 8'h01, 8'h00, 8'h00};
    vecs[6] = '{8'h00, 8'h00, 8'h00, 8'h00};

    rst_n = 1'b0; start = 1'b0; conv_done = 1'b0; conv_data = '0; out_ready = 1'b0;
    repeat (3) step();
    check("rst_valid", 32'(ov_a), 0);
    check("rst_data", 32'(od_a), 0);
    check("rst_last", 32'(ol_a), 0);
    check("rst_frame_done", 32'(fd_a), 0);
    check("rst_overflow", 32'(of_a), 0);
    check("rst_busy", 32'(bz_a), 0);

    rst_n = 1'b1;
    step();
    // conv_done in IDLE must not produce output
    conv_done = 1'b1; conv_data = 8'h55;
    step();
    conv_done = 1'b0;
    step();
    check("idle_ignore_valid", 32'(ov_a), 0);

    start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0;
    check("start_busy", 32'(bz_a), 1);

    // Post-processing vectors, each also checking the two-cycle latency
    for (int v = 0; v < 7; v++) begin
      conv_done = 1'b1; conv_data = vecs[v].din;
      step();
      conv_done = 1'b0;
      check("lat_t1_valid", 32'(ov_a), 0);
      step();
      check("lat_t2_valid", 32'(ov_a), 1);
      check("vec_data_a", 32'(od_a), 32'(vecs[v].ea));
      check("vec_data_b", 32'(od_b), 32'(vecs[v].eb));
      check("vec_data_c", 32'(od_c), 32'(vecs[v].ec));
      check("vec_last_a", 32'(ol_a), 0);
    end

    // Bring the frame to 50 samples, then reset mid-frame
    for (int i = 7; i < 50; i++) begin
      conv_done = 1'b1; conv_data = 8'(i);
      step();
    end
    conv_done = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(ov_a), 0);
    check("midrst_data", 32'(od_a), 0);
    check("midrst_last", 32'(ol_a), 0);
    check("midrst_overflow", 32'(of_a), 0);
    check("midrst_busy", 32'(bz_a), 0);
    for (int k = 0; k < 3; k++) begin
      check("midrst_no_frame_done", 32'(fd_a), 0);
      step();
    end
    rst_n = 1'b1;
    step();

    // Full frame at defaults, with a stray start during COLLECT
    exp_q.delete(); pop_cnt = 0; fd_cnt = 0; fd_pop_at = -1;
    mon_en = 1; out_ready = 1'b1;
    start = 1'b1;
    step();
    for (int i = 0; i < 196; i++) begin
      conv_done = 1'b1;
      conv_data = 8'(i - 100);
      start = (i == 50);
      exp_q.push_back('{(i < 100) ? 8'h00 : 8'(i - 100), (i == 195)});
      step();
    end
    conv_done = 1'b0; start = 1'b0;
    for (int k = 0; k < 40 && bz_a; k++) step();
    check("frame_busy_fall", 32'(bz_a), 0);
    check("frame_pops", 32'(pop_cnt), 196);
    check("frame_done_count", 32'(fd_cnt), 1);
    check("frame_done_after_last_pop", 32'(fd_pop_at), 196);
    check("frame_queue_left", 32'(exp_q.size()), 0);
    check("frame_overflow", 32'(of_a), 0);

    // Backpressure: 10 back-to-back results into an 8-deep FIFO
    pop_cnt = 0; out_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int j = 0; j < 10; j++) begin
      conv_done = 1'b1; conv_data = 8'(j + 1);
      if (j < 8) exp_q.push_back('{8'(j + 1), 1'b0});
      step();
      if (j == 8) check("bp_ovf_before_9th", 32'(of_a), 0);
      if (j == 9) check("bp_ovf_after_9th", 32'(of_a), 1);
    end
    conv_done = 1'b0;
    repeat (2) step();
    check("bp_hold_valid", 32'(ov_a), 1);
    check("bp_hold_head", 32'(od_a), 1);
    check("bp_overflow_sticky", 32'(of_a), 1);
    out_ready = 1'b1;
    repeat (12) step();
    check("bp_pops", 32'(pop_cnt), 8);
    check("bp_queue_left", 32'(exp_q.size()), 0);
    check("bp_empty", 32'(ov_a), 0);

    // Full FIFO with a push and pop in the same cycle
    rst_n = 1'b0; out_ready = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    pop_cnt = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int j = 0; j < 12; j++) begin
      out_ready = (j >= 9);
      conv_done = 1'b1; conv_data = 8'(8'h11 + j);
      exp_q.push_back('{8'(8'h11 + j), 1'b0});
      step();
      if (j == 8) check("full_valid", 32'(ov_a), 1);
    end
    conv_done = 1'b0;
    repeat (15) step();
    check("full_pops", 32'(pop_cnt), 12);
    check("full_queue_left", 32'(exp_q.size()), 0);
    check("full_no_overflow", 32'(of_a), 0);
    mon_en = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
